// File: rtl/oem_out_serializer.sv
// Output stage of the odd-even merge sorter: buffers up to two sorted vectors
// and streams their elements out lowest lane first on a ready/valid port.
module oem_out_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int N          = 8,
   parameter int IDX_W      = $clog2(N)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [N*DATA_WIDTH-1:0] in_data,
   output logic                    in_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic [IDX_W-1:0]        out_index,
   output logic                    out_last,
   output logic                    overflow,
   output logic [7:0]              drop_cnt
);

   // state | meaning
   // EMPTY | no vector buffered, output idle
   // ONE   | one vector buffered, streaming from slot[rp]
   // FULL  | both slots hold vectors; new arrivals drop unless the head drains
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_e;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   occ_e                    occ_q, occ_d;
   logic                    wp_q, wp_d;
   logic                    rp_q, rp_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    overflow_q, overflow_d;
   logic [7:0]              drop_cnt_q, drop_cnt_d;
   logic [N*DATA_WIDTH-1:0] slot0_q, slot0_d;
   logic [N*DATA_WIDTH-1:0] slot1_q, slot1_d;
   logic [N*DATA_WIDTH-1:0] head_vec;
   logic [DATA_WIDTH-1:0]   head_lane [N];
   logic                    hs;
   logic                    drain;
   logic                    capture;
   logic                    drop;

   assign head_vec = rp_q ? slot1_q : slot0_q;

   for (genvar k = 0; k < N; k++) begin : g_lane
      assign head_lane[k] = head_vec[k*DATA_WIDTH +: DATA_WIDTH];
   end

   // Outputs depend on registered state only; out_ready feeds next-state logic.
   assign out_valid = (occ_q != EMPTY);
   assign out_data  = out_valid ? head_lane[idx_q] : '0;
   assign out_index = idx_q;
   assign out_last  = out_valid & (idx_q == LAST_IDX);
   assign in_ready  = (occ_q != FULL);
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;

   assign hs      = out_valid & out_ready;
   assign drain   = hs & (idx_q == LAST_IDX);
   assign capture = in_valid & ((occ_q != FULL) | drain);
   assign drop    = in_valid & (occ_q == FULL) & ~drain;

   always_comb begin
      occ_d      = occ_q;
      wp_d       = wp_q;
      rp_d       = rp_q;
      idx_d      = idx_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      slot0_d    = slot0_q;
      slot1_d    = slot1_q;

      case (occ_q)
         EMPTY: if (capture) occ_d = ONE;
         ONE: begin
            if (capture & ~drain)      occ_d = FULL;
            else if (drain & ~capture) occ_d = EMPTY;
         end
         FULL:    if (drain & ~capture) occ_d = ONE;
         default: occ_d = EMPTY;
      endcase

      if (capture) begin
         wp_d = ~wp_q;
         if (wp_q) slot1_d = in_data;
         else      slot0_d = in_data;
      end

      if (hs) begin
         if (idx_q == LAST_IDX) begin
            idx_d = '0;
            rp_d  = ~rp_q;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end

      if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q      <= EMPTY;
         wp_q       <= 1'b0;
         rp_q       <= 1'b0;
         idx_q      <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         occ_q      <= occ_d;
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         idx_q      <= idx_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Slot contents are don't-care after reset; occupancy alone gates the output.
   always_ff @(posedge clk) begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
   end

endmodule

// File: doc/oem_out_serializer.md
# oem_out_serializer

Output stage of the odd-even merge sorting network. It captures each sorted N-element vector produced by the final compare-and-exchange column (one vector per `in_valid` pulse) into a two-slot buffer. It streams the elements out one per handshake on a ready/valid port, lowest lane first. The network has no backpressure, so a vector that arrives while both slots are occupied is dropped and flagged.

## Interface
- `DATA_WIDTH`, default 8: element width in bits.
- `N`, default 8: elements per vector; power of two, N ≥ 2.
- `IDX_W`, default $clog2(N): width of the element index.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  sorted vector present on `in_data` this cycle (single-cycle pulse per vector).
- `in_data`  in  N*DATA_WIDTH  sorted vector; lane k = `in_data[k*DATA_WIDTH +: DATA_WIDTH]`.
- `in_ready`  out  1  at least one buffer slot is free; informational only, because upstream does not stall.
- `out_valid`  out  1  `out_data` holds a valid element.
- `out_ready`  in  1  consumer accepts the element this cycle.
- `out_data`  out  DATA_WIDTH  current element; 0 when `out_valid`=0.
- `out_index`  out  IDX_W  lane number of the current element; 0 when idle.
- `out_last`  out  1  current element is lane N-1.
- `overflow`  out  1  sticky; set when a vector is dropped.
- `drop_cnt`  out  8  number of dropped vectors, saturating at 255.

## Operation
- Storage: two slots of N*DATA_WIDTH bits each, a write pointer `wp`, a read pointer `rp`, an occupancy counter `occ` (0..2), and an element index `idx` (IDX_W bits).
- Occupancy states:
  - EMPTY (`occ`=0)
  - ONE (`occ`=1)
  - FULL (`occ`=2)
- Handshake `hs` = `out_valid & out_ready`. Drain event `drain` = `hs & (idx == N-1)`.
- Capture: the vector is written into slot[`wp`], `wp` toggles and `occ` increments if `in_valid & (occ < 2 | drain)`.
  - A vector arriving in FULL on the same cycle the head slot drains is accepted. In that case `occ` stays 2.
- Drop: on `in_valid & occ==2 & ~drain`:
  - the vector is discarded and the buffer is unchanged;
  - `overflow` <= 1;
  - `drop_cnt` increments unless it is already 255.
- Read side:
  - `out_valid` = (`occ` != 0).
  - `out_data` = lane `idx` of slot[`rp`].
  - `out_index` = `idx`.
  - `out_last` = `out_valid & (idx == N-1)`.
- On `hs`: if `idx` < N-1, `idx` increments. Otherwise `idx` <= 0, `rp` toggles and `occ` decrements (net change is 0 if a capture happens in the same cycle).
- No `hs` means `idx`, `rp` and `out_data` hold. Output values must stay stable while `out_valid & ~out_ready`.
- `in_ready` = (`occ` < 2).
- Element values pass through bit-exact. The block never interprets data as signed or unsigned.

## Timing
- Reset state: `occ`=0, `wp`=`rp`=0, `idx`=0, `overflow`=0, `drop_cnt`=0, and buffer contents are don't-care. Consequently:
  - `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0;
  - `in_ready`=1.
- `rst` has priority over every other input. Asserting it mid-stream discards both slots and any `in_valid` in that cycle.
- Latency: for a vector captured at edge t into an empty buffer, `out_valid`=1 with lane 0 during cycle t+1.
- Throughput: with `out_ready` held at 1 and a second vector buffered, lane N-1 of vector A is followed in the very next cycle by lane 0 of vector B. There are no bubbles.
- Sustained input rate without loss is one vector per N cycles at full drain. Two vectors may arrive back-to-back into an EMPTY buffer without loss.
- Outputs are combinational from registered state only. There is no combinational path from `in_*` to `out_*`. `out_ready` affects only next-state logic.

## Test plan
- **Single vector.** Reset, then one `in_valid` with lanes 0..7 = 3,9,17,20,41,66,200,255, and `out_ready`=1. Required: lanes appear on cycles t+1..t+8 in order with `out_index` 0..7, `out_last` only on 255, then `out_valid`=0.
- **Backpressure.** Same vector with `out_ready` toggling 1,0,0,1,... Required: `out_data`/`out_index` hold during every low cycle. All 8 elements are delivered once, in order.
- **Back-to-back vectors.** Vectors A and B arrive on consecutive cycles and `out_ready`=1. Required: 16 contiguous valid cycles A0..A7,B0..B7, `in_ready`=0 after the second capture, and `overflow`=0.
- **Overflow.** `out_ready`=0 and vectors A, B, C arrive on 3 cycles. Required: C is dropped, `overflow`=1, `drop_cnt`=1. Then with `out_ready`=1, only A and B stream out.
- **Capture on drain.** FULL buffer with A at `idx`=7 and `out_ready`=1, and vector C arrives in that cycle. Required: C is accepted, `occ` stays 2, `drop_cnt` is unchanged, and the stream is B then C.
- **Reset mid-stream.** Assert `rst` for 1 cycle at A3 with B buffered. Required: the next cycle has `out_valid`=0, `overflow`=0, `drop_cnt`=0, and a new vector afterwards streams from lane 0.
